// File: rtl/log_mult_arbiter_if.sv
// Request/multiplier/response bundle shared between the log_mult_arbiter and its neighbours.
// Optional LOG_MULT_ARB_STATS_EN adds the txn_count output.
interface log_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [7:0]           mul_a;
  logic [7:0]           mul_b;
  logic [15:0]          mul_result;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_result;
`ifdef LOG_MULT_ARB_STATS_EN
  logic [15:0]          txn_count;

  modport slave (
    input  req_valid, req_a, req_b, mul_result, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, txn_count
  );
  modport master (
    output req_valid, req_a, req_b, mul_result, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, txn_count
  );
`else
  modport slave (
    input  req_valid, req_a, req_b, mul_result, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result
  );
  modport master (
    output req_valid, req_a, req_b, mul_result, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result
  );
`endif
endinterface

// File: rtl/log_mult_arbiter.sv
// Round-robin share of one combinational multiplier: accept -> 1 settle cycle -> registered response,
// held in RESP while rsp_ready is low. LOG_MULT_ARB_STATS_EN adds a saturating txn_count.
module log_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  log_mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

  state_t          state_q, state_d;
  logic [7:0]      op_a_q, op_a_d;
  logic [7:0]      op_b_q, op_b_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [15:0]     rsp_result_q, rsp_result_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic               found;
  logic [ID_W-1:0]    win;
  logic [NUM_REQ-1:0] grant_oh;
  logic [7:0]         sel_a;
  logic [7:0]         sel_b;
  int                 tgt;

  // Search offsets 1..NUM_REQ from last_grant; the first valid requester wins.
  always_comb begin
    found    = 1'b0;
    win      = last_grant_q;
    grant_oh = '0;
    sel_a    = 8'h00;
    sel_b    = 8'h00;
    tgt      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      tgt = int'(last_grant_q) + off;
      if (tgt >= NUM_REQ) tgt = tgt - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == tgt) && bus.req_valid[j]) begin
          found       = 1'b1;
          win         = ID_W'(j);
          grant_oh[j] = 1'b1;
          sel_a       = bus.req_a[8*j +: 8];
          sel_b       = bus.req_b[8*j +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    cur_id_d     = cur_id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_a_d       = sel_a;
          op_b_d       = sel_b;
          cur_id_d     = win;
          last_grant_d = win;
          state_d      = CALC;
        end
      end
      CALC: begin
        rsp_result_d = bus.mul_result;
        rsp_id_d     = cur_id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q       <= 8'h00;
      op_b_q       <= 8'h00;
      cur_id_q     <= '0;
      last_grant_q <= LAST_INIT;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 16'h0000;
      rsp_id_q     <= '0;
    end else begin
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      cur_id_q     <= cur_id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  // Grant is masked during reset so nothing is handed out on a cycle that will be discarded.
  always_comb begin
    bus.req_ready = '0;
    if ((state_q == IDLE) && found && !rst) bus.req_ready = grant_oh;
  end

  assign bus.mul_a      = op_a_q;
  assign bus.mul_b      = op_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_id     = rsp_id_q;

`ifdef LOG_MULT_ARB_STATS_EN
  logic [15:0] txn_count_q, txn_count_d;

  always_comb begin
    txn_count_d = txn_count_q;
    if (rsp_valid_q && bus.rsp_ready && (txn_count_q != 16'hFFFF))
      txn_count_d = txn_count_q + 16'h0001;
  end

  always_ff @(posedge clk) begin
    if (rst) txn_count_q <= 16'h0000;
    else     txn_count_q <= txn_count_d;
  end

  assign bus.txn_count = txn_count_q;
`endif

endmodule

// File: tb/tb_log_mult_arbiter.sv
// Directed bench for log_mult_arbiter with an exact-product model of the shared multiplier.
module tb_log_mult_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  log_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  log_mult_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic signed [15:0] ext_a, ext_b;
  assign ext_a          = 16'($signed(bus.mul_a));
  assign ext_b          = 16'($signed(bus.mul_b));
  assign bus.mul_result = ext_a * ext_b;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*i +: 8] = a;
    bus.req_b[8*i +: 8] = b;
  endtask

  // One isolated transaction from requester id; rsp_ready is assumed high.
  task automatic txn(input string tag, input int id, input logic [7:0] a,
                     input logic [7:0] b, input logic [15:0] exp_res);
    set_ops(id, a, b);
    bus.req_valid = 4'(1 << id);
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << id));
    tick();
    bus.req_valid = '0;
    check({tag, "_calc_vld"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_mul_a"}, 32'(bus.mul_a), 32'(a));
    tick();
    check({tag, "_vld"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_res"}, 32'(bus.rsp_result), 32'(exp_res));
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    tick();
    check({tag, "_done"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  int          exp_ids [6] = '{0, 1, 2, 3, 0, 1};
  logic [15:0] exp_prod[6] = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd3, 16'd6};

  initial begin
    bus.req_valid = 4'hF;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #1;
    check("rst_cycle_ready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    bus.req_valid = '0;
    rst = 1'b0;
    #1;
    check("rst_vld", 32'(bus.rsp_valid), 32'd0);
    check("rst_res", 32'(bus.rsp_result), 32'd0);
    check("rst_id", 32'(bus.rsp_id), 32'd0);
    check("rst_mul_a", 32'(bus.mul_a), 32'd0);
    check("rst_mul_b", 32'(bus.mul_b), 32'd0);
    check("idle_ready", 32'(bus.req_ready), 32'd0);

    txn("single", 2, 8'd4, 8'd8, 16'd32);
    check("mul_a_stable", 32'(bus.mul_a), 32'd4);
    txn("neg", 1, 8'hF0, 8'd2, 16'hFFE0);
    txn("zero", 0, 8'd0, 8'hF9, 16'h0000);

    // Fairness from a fresh reset with all four requesters contending.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, 8'(i + 1), 8'd3);
    bus.req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", 32'(bus.req_ready), 32'(1 << exp_ids[k]));
      tick();
      tick();
      check("rr_id", 32'(bus.rsp_id), 32'(exp_ids[k]));
      check("rr_res", 32'(bus.rsp_result), 32'(exp_prod[k]));
      tick();
    end

    // Back-pressure: requester 2 is next.
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_vld", 32'(bus.rsp_valid), 32'd1);
      check("bp_id", 32'(bus.rsp_id), 32'd2);
      check("bp_res", 32'(bus.rsp_result), 32'd9);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release_vld", 32'(bus.rsp_valid), 32'd1);
    tick();
    check("bp_done", 32'(bus.rsp_valid), 32'd0);
    check("bp_next_ready", 32'(bus.req_ready), 32'b1000);

    // Reset in CALC drops requester 3's transaction.
    tick();
    check("calc_mul_a", 32'(bus.mul_a), 32'd4);
    rst = 1'b1;
    tick();
    check("midrst_ready", 32'(bus.req_ready), 32'd0);
    check("midrst_vld", 32'(bus.rsp_valid), 32'd0);
    check("midrst_mul_a", 32'(bus.mul_a), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_winner", 32'(bus.req_ready), 32'b0001);
    tick();
    tick();
    check("midrst_id", 32'(bus.rsp_id), 32'd0);
    check("midrst_res", 32'(bus.rsp_result), 32'd3);
    tick();
    bus.req_valid = '0;

`ifdef LOG_MULT_ARB_STATS_EN
    txn("st1", 1, 8'd2, 8'd2, 16'd4);
    txn("st2", 3, 8'd5, 8'd5, 16'd25);
    check("txn_count_3", 32'(bus.txn_count), 32'd3);
    force dut.txn_count_q = 16'hFFFE;
    #1;
    release dut.txn_count_q;
    txn("sat1", 0, 8'd1, 8'd1, 16'd1);
    txn("sat2", 0, 8'd1, 8'd2, 16'd2);
    check("txn_count_sat", 32'(bus.txn_count), 32'h0000FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
